// File: rtl/serial_tx.sv
// Framed serializer: latches a word on valid/ready and shifts it out as
// START(0), DATA LSB-first, STOP(1), each bit held CLKS_PER_BIT cycles.
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              busy,
   output logic              done
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q;
   logic [DIV_W-1:0]  div_cnt_q;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              ser_out_q;
   logic              busy_q;
   logic              done_q;

   assign in_ready = (state_q == IDLE) && !rst;
   assign ser_out  = ser_out_q;
   assign busy     = busy_q;
   assign done     = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ser_out_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_q   <= START;
                  shift_q   <= in_data;
                  div_cnt_q <= '0;
                  ser_out_q <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (div_cnt_q == DIV_LAST) begin
                  state_q   <= DATA;
                  div_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  ser_out_q <= shift_q[0];
                  shift_q   <= shift_q >> 1;
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     // Last payload bit finished: line goes to the stop level.
                     state_q   <= STOP;
                     bit_cnt_q <= '0;
                     ser_out_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     ser_out_q <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (div_cnt_q == DIV_LAST) begin
                  state_q   <= IDLE;
                  div_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Randomized self-checking bench for serial_tx: a C=4 and a C=1 instance,
// each line cycle compared with a waveform derived from the frame format.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       valid4, valid1;
   logic       rdy4, ser4, busy4, done4;
   logic       rdy1, ser1, busy1, done1;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid4),
      .in_ready(rdy4), .ser_out(ser4), .busy(busy4), .done(done4));

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid1),
      .in_ready(rdy1), .ser_out(ser1), .busy(busy1), .done(done1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic get_ser(input bit sel);
      return sel ? ser1 : ser4;
   endfunction
   function automatic logic get_busy(input bit sel);
      return sel ? busy1 : busy4;
   endfunction
   function automatic logic get_done(input bit sel);
      return sel ? done1 : done4;
   endfunction
   function automatic logic get_rdy(input bit sel);
      return sel ? rdy1 : rdy4;
   endfunction

   // Line level t cycles into a frame: bit slot t/c is start, data[0..7], stop.
   function automatic logic exp_line(input logic [7:0] w, input int c, input int t);
      int idx;
      idx = t / c;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return w[idx-1];
      return 1'b1;
   endfunction

   task automatic check_idle(input bit sel, input string tag);
      check({tag, "_ser"},  get_ser(sel),  1);
      check({tag, "_busy"}, get_busy(sel), 0);
      check({tag, "_done"}, get_done(sel), 0);
   endtask

   // Sends one frame starting from an idle cycle; optionally keeps in_valid
   // asserted with the next word, or pulses reset at frame cycle abort_at.
   task automatic tx_frame(input bit sel, input logic [7:0] w, input bit hold,
                           input logic [7:0] nxt, input int abort_at);
      int c;
      int n;
      c = sel ? 1 : 4;
      n = 10 * c;
      check("rdy_pre", get_rdy(sel), 1);
      in_data = w;
      if (sel) valid1 = 1'b1; else valid4 = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (!hold) begin
         valid1 = 1'b0;
         valid4 = 1'b0;
      end
      for (int t = 0; t < n; t++) begin
         if (t > 0) begin
            @(posedge clk); #1;
         end
         check("ser",  get_ser(sel),  exp_line(w, c, t));
         check("busy", get_busy(sel), 1);
         check("done", get_done(sel), 0);
         check("rdy",  get_rdy(sel),  0);
         in_data = (t == 9) ? 8'h5A : 8'($urandom);
         if (t == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            check_idle(sel, "abort");
            check("abort_rdy", get_rdy(sel), 1);
            return;
         end
      end
      if (hold) in_data = nxt;
      @(posedge clk); #1;
      check("end_done", get_done(sel), 1);
      check("end_busy", get_busy(sel), 0);
      check("end_ser",  get_ser(sel),  1);
      check("end_rdy",  get_rdy(sel),  1);
      if (!hold) begin
         @(posedge clk); #1;
         check_idle(sel, "post");
      end
   endtask

   initial begin
      int a0;
      rst = 1'b1;
      valid4 = 1'b0;
      valid1 = 1'b0;
      in_data = 8'h00;

      repeat (2) begin
         @(posedge clk); #1;
         check_idle(0, "rst4");
         check_idle(1, "rst1");
         check("rst_rdy4", rdy4, 0);
         check("rst_rdy1", rdy1, 0);
      end
      rst = 1'b0;
      #1;
      check("rdy4_after_rst", rdy4, 1);
      check("rdy1_after_rst", rdy1, 1);
      @(posedge clk); #1;
      check_idle(0, "idle4");
      check_idle(1, "idle1");

      tx_frame(0, 8'hA5, 0, 8'h00, -1);

      tx_frame(0, 8'h00, 1, 8'hFF, -1);
      a0 = acc_cyc;
      tx_frame(0, 8'hFF, 0, 8'h00, -1);
      check("b2b_period4", acc_cyc - a0, 41);

      tx_frame(0, 8'hC3, 0, 8'h00, -1);

      tx_frame(0, 8'h3C, 0, 8'h00, 14);
      repeat (3) begin
         @(posedge clk); #1;
         check_idle(0, "after_abort");
      end
      tx_frame(0, 8'h3C, 0, 8'h00, -1);

      for (int i = 0; i < 12; i++) begin
         tx_frame(0, 8'($urandom), 0, 8'h00, -1);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            check_idle(0, "gap4");
         end
      end

      tx_frame(1, 8'h81, 0, 8'h00, -1);
      tx_frame(1, 8'($urandom), 1, 8'h96, -1);
      a0 = acc_cyc;
      tx_frame(1, 8'h96, 0, 8'h00, -1);
      check("b2b_period1", acc_cyc - a0, 11);
      for (int i = 0; i < 12; i++) begin
         tx_frame(1, 8'($urandom), 0, 8'h00, -1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check_idle(1, "gap1");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
